// File: rtl/reset_pkg.sv
// rtl/reset_pkg.sv - shared state encoding and parameter range limits for the reset sequencer
package reset_pkg;

    typedef enum logic [1:0] {
        S_POR,
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_e;

    localparam int     N_CH_MIN = 1;
    localparam int     N_CH_MAX = 16;
    localparam longint LEN_MIN  = 1;

    // A length must be at least one cycle and representable in the down-counter.
    function automatic bit len_fits(input longint len, input int cnt_w);
        return (len >= LEN_MIN) && (len <= longint'((64'd1 << cnt_w) - 64'd1));
    endfunction

endpackage

// File: rtl/rst_sync.sv
// rtl/rst_sync.sv - 2-FF reset synchroniser: asynchronous assert, synchronous release
module rst_sync (
    input  logic clk_i,
    input  logic arst_i,
    output logic rst_o
);

    logic [1:0] sync_q = 2'b11;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst_o = sync_q[1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - power-on / soft reset sequencer with staggered per-domain release
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int POR_CYCLES = 65535,
    parameter int STAGGER    = 16,
    parameter int MIN_PULSE  = 256,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            soft_req,
    output logic [N_CH-1:0] rst_out,
    output logic            all_released,
    output logic            busy
);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX
        || !len_fits(longint'(POR_CYCLES), CNT_W)
        || !len_fits(longint'(STAGGER), CNT_W)
        || !len_fits(longint'(MIN_PULSE), CNT_W)) begin : g_param_check
        $error("reset_sequencer: parameter out of range");
    end

    localparam logic [CNT_W-1:0] POR_LOAD   = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LOAD  = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(MIN_PULSE - 1);
    localparam logic [N_CH-1:0]  ALL_ONES   = '1;
    localparam logic [N_CH-1:0]  FIRST_MASK = ALL_ONES << 1;

    state_e           state_q = S_POR;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q   = POR_LOAD;
    logic [CNT_W-1:0] cnt_d;
    logic [N_CH-1:0]  mask_q  = ALL_ONES;
    logic [N_CH-1:0]  mask_d;
    logic [N_CH-1:0]  mask_shift;
    logic             por_hold;

    rst_sync u_rst_sync (
        .clk_i  (clk),
        .arst_i (rst_in),
        .rst_o  (por_hold)
    );

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_POR;
            cnt_q   <= POR_LOAD;
            mask_q  <= ALL_ONES;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    assign mask_shift = mask_q << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            S_POR: begin
                if (por_hold) begin
                    cnt_d = POR_LOAD;
                end else if (cnt_q == '0) begin
                    mask_d  = FIRST_MASK;
                    cnt_d   = STAG_LOAD;
                    state_d = (FIRST_MASK == '0) ? S_RUN : S_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // HOLD ends exactly like POR: bit 0 drops on the exit edge.
            S_HOLD: begin
                if (cnt_q == '0) begin
                    mask_d  = FIRST_MASK;
                    cnt_d   = STAG_LOAD;
                    state_d = (FIRST_MASK == '0) ? S_RUN : S_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (cnt_q == '0) begin
                    mask_d = mask_shift;
                    cnt_d  = STAG_LOAD;
                    if (mask_shift == '0) begin
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (soft_req) begin
                    mask_d  = ALL_ONES;
                    cnt_d   = HOLD_LOAD;
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_POR;
                cnt_d   = POR_LOAD;
                mask_d  = ALL_ONES;
            end
        endcase
    end

    assign rst_out      = mask_q;
    assign all_released = ~|mask_q;
    assign busy         = (state_q != S_RUN);

endmodule
